// File: rtl/mem_responder.sv
// ----------------------------------------------------------------------------
// mem_responder
//
// Bus-side responder for the multicycle CPU memory port. Accepts one load or
// store (word / half / byte) at a time and services it against an internal
// word-organised RAM. Sub-word stores are done as an internal
// read-modify-write. Every request is answered with a one-cycle `ready`
// pulse; illegal requests additionally raise `err` and never touch the RAM.
//
// Parameters
//   ADDR_W    : word-index bits; RAM holds 2**ADDR_W 32-bit words and the
//               legal byte window is [0, 2**(ADDR_W+2)).
//   READ_WAIT : extra wait cycles before every access (0..15).
//
// Ports
//   clk    in   clock, rising-edge
//   reset  in   asynchronous active-low reset
//   req    in   request strobe (accepted in IDLE, or on the DONE exit edge)
//   wr     in   1 = store, 0 = load
//   size   in   00 word, 01 half, 10 byte, 11 illegal
//   addr   in   byte address
//   wdata  in   store data, low 8/16/32 bits used by size
//   ready  out  one-cycle completion pulse
//   err    out  high with ready when the request was rejected
//   rdata  out  load result, right-aligned, zero-extended; held until the
//               next ready
//   busy   out  high whenever the FSM is not in IDLE
//
// The completion outputs are registered from the DONE state, so they appear
// in the cycle after the edge that leaves DONE. That edge may also accept the
// next request, allowing back-to-back operation without dropping busy.
// ----------------------------------------------------------------------------
module mem_responder #(
   parameter int ADDR_W    = 8,
   parameter int READ_WAIT = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        ready,
   output logic        err,
   output logic [31:0] rdata,
   output logic        busy
);

   localparam int         BYTE_W    = ADDR_W + 2;
   localparam logic [3:0] WAIT_INIT = 4'(READ_WAIT);

   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_BYTE = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_ACCESS,
      S_MERGE,
      S_DONE
   } state_t;

   state_t state_q, state_d;

   // Latched request
   logic              wr_q;
   logic [1:0]        size_q;
   logic [BYTE_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic              bad_q;

   logic [3:0]        cnt_q;
   logic [31:0]       data_q;

   // RAM
   logic [31:0]       mem [1 << ADDR_W];
   logic [ADDR_W-1:0] word_idx;

   // Control decoded from the current state
   logic              accept;
   logic              illegal;
   state_t            start_state;
   logic              ram_we;
   logic [31:0]       ram_wdata;
   logic              load_data;
   logic [31:0]       merged;
   logic [31:0]       extracted;

   assign word_idx = addr_q[BYTE_W-1:2];
   assign busy     = (state_q != S_IDLE);

   // DONE counts as an accepting state: the edge that leaves DONE can take
   // the next request directly, so busy stays high across back-to-back ops.
   assign accept   = req && ((state_q == S_IDLE) || (state_q == S_DONE));

   // -------------------------------------------------------------------------
   // Legality of the incoming request
   // -------------------------------------------------------------------------
   // NOTE: every variable assigned in an always_comb gets a default at the top
   // of the block; a path that leaves one unassigned would infer a latch.
   always_comb begin
      illegal = 1'b0;
      case (size)
         SZ_WORD: illegal = (addr[1:0] != 2'b00);
         SZ_HALF: illegal = addr[0];
         SZ_BYTE: illegal = 1'b0;
         default: illegal = 1'b1;
      endcase
      if (addr[31:BYTE_W] != '0) begin
         illegal = 1'b1;
      end
   end

   // First state after acceptance; illegal requests skip straight to DONE.
   always_comb begin
      start_state = S_ACCESS;
      if (illegal) begin
         start_state = S_DONE;
      end else if (WAIT_INIT != 4'd0) begin
         start_state = S_WAIT;
      end
   end

   // -------------------------------------------------------------------------
   // Lane manipulation on the data register (little-endian lanes)
   // -------------------------------------------------------------------------
   always_comb begin
      merged = data_q;
      if (size_q == SZ_BYTE) begin
         merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end else if (size_q == SZ_HALF) begin
         merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
   end

   always_comb begin
      extracted = 32'h0;
      case (size_q)
         SZ_WORD: extracted = data_q;
         SZ_HALF: extracted = {16'h0, data_q[{addr_q[1], 4'b0000} +: 16]};
         SZ_BYTE: extracted = {24'h0, data_q[{addr_q[1:0], 3'b000} +: 8]};
         default: extracted = 32'h0;
      endcase
   end

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   // NOTE: clocked blocks use non-blocking assignments only, so every register
   // samples the pre-edge values of the others regardless of block order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next state and RAM/data-register strobes
   // -------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      ram_we    = 1'b0;
      ram_wdata = wdata_q;
      load_data = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = start_state;
            end
         end
         S_WAIT: begin
            // The counter is loaded with READ_WAIT; the last wait cycle is the
            // one where it reads 1.
            if (cnt_q == 4'd1) begin
               state_d = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (!wr_q) begin
               load_data = 1'b1;
               state_d   = S_DONE;
            end else if (size_q == SZ_WORD) begin
               ram_we    = 1'b1;
               ram_wdata = wdata_q;
               state_d   = S_DONE;
            end else begin
               load_data = 1'b1;
               state_d   = S_MERGE;
            end
         end
         S_MERGE: begin
            ram_we    = 1'b1;
            ram_wdata = merged;
            state_d   = S_DONE;
         end
         S_DONE: begin
            state_d = accept ? start_state : S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Request latch, wait counter, data register and completion outputs
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_q    <= 1'b0;
         size_q  <= SZ_WORD;
         addr_q  <= '0;
         wdata_q <= 32'h0;
         bad_q   <= 1'b0;
         cnt_q   <= 4'd0;
         data_q  <= 32'h0;
         ready   <= 1'b0;
         err     <= 1'b0;
         rdata   <= 32'h0;
      end else begin
         if (accept) begin
            wr_q    <= wr;
            size_q  <= size;
            addr_q  <= addr[BYTE_W-1:0];
            wdata_q <= wdata;
            bad_q   <= illegal;
            cnt_q   <= illegal ? 4'd0 : WAIT_INIT;
         end else if (state_q == S_WAIT) begin
            cnt_q <= cnt_q - 4'd1;
         end

         if (load_data) begin
            data_q <= mem[word_idx];
         end

         // Outputs reflect the request finishing in DONE; when DONE accepts a
         // new request on the same edge these still use the old request's
         // latched fields.
         ready <= (state_q == S_DONE);
         err   <= (state_q == S_DONE) && bad_q;
         if (state_q == S_DONE) begin
            rdata <= (bad_q || wr_q) ? 32'h0 : extracted;
         end
      end
   end

   // -------------------------------------------------------------------------
   // RAM write port. A reset forces the FSM out of ACCESS/MERGE, which drops
   // ram_we, so an abandoned store never lands.
   // -------------------------------------------------------------------------
   // NOTE: the RAM array is deliberately left without a reset; its contents
   // survive `reset`, and a resettable array would not map onto RAM macros.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         mem[word_idx] <= ram_wdata;
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_mem_responder
//
// Two responders share the clock, reset and request fields: dut0 with
// READ_WAIT = 0 and dut3 with READ_WAIT = 3, each with its own req strobe.
// Expected completions are queued when a request is driven and compared by a
// per-DUT monitor when `ready` pulses. Scenario tasks check latency, busy,
// reset behaviour and back-to-back acceptance inline.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        req0, req3;
   logic        ready0, err0, busy0;
   logic        ready3, err3, busy3;
   logic [31:0] rdata0, rdata3;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t q0[$];
   exp_t q3[$];

   always #5 clk = ~clk;

   mem_responder #(.ADDR_W(8), .READ_WAIT(0)) dut0 (
      .clk(clk), .reset(reset), .req(req0), .wr(wr), .size(size), .addr(addr),
      .wdata(wdata), .ready(ready0), .err(err0), .rdata(rdata0), .busy(busy0)
   );

   mem_responder #(.ADDR_W(8), .READ_WAIT(3)) dut3 (
      .clk(clk), .reset(reset), .req(req3), .wr(wr), .size(size), .addr(addr),
      .wdata(wdata), .ready(ready3), .err(err3), .rdata(rdata3), .busy(busy3)
   );

   // Scoreboard monitors: sample mid-cycle, one pop per ready pulse.
   always @(negedge clk) begin : mon0
      exp_t e;
      if (reset && ready0) begin
         if (q0.size() == 0) begin
            total++; bad++;
            $display("FAIL sb0_unexpected_ready got=1 expected=0");
         end else begin
            e = q0.pop_front();
            total++;
            if (rdata0 !== e.rdata) begin
               bad++;
               $display("FAIL sb0_rdata got=%h expected=%h", rdata0, e.rdata);
            end
            total++;
            if (err0 !== e.err) begin
               bad++;
               $display("FAIL sb0_err got=%b expected=%b", err0, e.err);
            end
         end
      end
   end

   always @(negedge clk) begin : mon3
      exp_t e;
      if (reset && ready3) begin
         if (q3.size() == 0) begin
            total++; bad++;
            $display("FAIL sb3_unexpected_ready got=1 expected=0");
         end else begin
            e = q3.pop_front();
            total++;
            if (rdata3 !== e.rdata) begin
               bad++;
               $display("FAIL sb3_rdata got=%h expected=%h", rdata3, e.rdata);
            end
            total++;
            if (err3 !== e.err) begin
               bad++;
               $display("FAIL sb3_err got=%b expected=%b", err3, e.err);
            end
         end
      end
   end

   // Drive one request, queue its expected completion, and measure the number
   // of edges after the accepting edge until ready is seen (-1 on timeout).
   task automatic send(input int which, input logic w, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input logic exp_err,
                       output int lat, output logic busy_t);
      exp_t e;
      @(negedge clk);
      wr = w; size = sz; addr = a; wdata = d;
      e.rdata = exp_rd; e.err = exp_err;
      if (which == 0) begin q0.push_back(e); req0 = 1'b1; end
      else            begin q3.push_back(e); req3 = 1'b1; end
      @(posedge clk);
      #1;
      req0 = 1'b0; req3 = 1'b0;
      busy_t = (which == 0) ? busy0 : busy3;
      lat = -1;
      for (int k = 1; k <= 30; k++) begin
         @(posedge clk);
         #1;
         if (((which == 0) ? ready0 : ready3) === 1'b1) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; req0 = 1'b0; req3 = 1'b0;
      wr = 1'b0; size = 2'b00; addr = 32'h0; wdata = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      total++; if (ready0 !== 1'b0) begin bad++; $display("FAIL rst_ready0 got=%b expected=0", ready0); end
      total++; if (err0 !== 1'b0)   begin bad++; $display("FAIL rst_err0 got=%b expected=0", err0); end
      total++; if (busy0 !== 1'b0)  begin bad++; $display("FAIL rst_busy0 got=%b expected=0", busy0); end
      total++; if (rdata0 !== 32'h0) begin bad++; $display("FAIL rst_rdata0 got=%h expected=0", rdata0); end
      total++; if (busy3 !== 1'b0)  begin bad++; $display("FAIL rst_busy3 got=%b expected=0", busy3); end
      total++; if (ready3 !== 1'b0) begin bad++; $display("FAIL rst_ready3 got=%b expected=0", ready3); end
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_word();
      int lat; logic bz;
      send(0, 1'b1, 2'b00, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, lat, bz);
      total++; if (lat != 2) begin bad++; $display("FAIL word_store_lat got=%0d expected=2", lat); end
      total++; if (bz !== 1'b1) begin bad++; $display("FAIL word_store_busy got=%b expected=1", bz); end
      send(0, 1'b0, 2'b00, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, lat, bz);
      total++; if (lat != 2) begin bad++; $display("FAIL word_load_lat got=%0d expected=2", lat); end
      @(posedge clk);
      #1;
      total++; if (ready0 !== 1'b0) begin bad++; $display("FAIL ready_one_cycle got=%b expected=0", ready0); end
      total++; if (rdata0 !== 32'hDEADBEEF) begin bad++; $display("FAIL rdata_hold got=%h expected=deadbeef", rdata0); end
   endtask

   task automatic test_byte();
      int lat; logic bz;
      send(0, 1'b1, 2'b10, 32'h11, 32'hFFFF_FFAA, 32'h0, 1'b0, lat, bz);
      total++; if (lat != 3) begin bad++; $display("FAIL byte_store_lat got=%0d expected=3", lat); end
      send(0, 1'b0, 2'b00, 32'h10, 32'h0, 32'hDEADAAEF, 1'b0, lat, bz);
      total++; if (lat != 2) begin bad++; $display("FAIL byte_word_lat got=%0d expected=2", lat); end
      send(0, 1'b0, 2'b10, 32'h13, 32'h0, 32'h0000_00DE, 1'b0, lat, bz);
      total++; if (lat != 2) begin bad++; $display("FAIL byte_load_lat got=%0d expected=2", lat); end
   endtask

   task automatic test_half();
      int lat; logic bz;
      send(0, 1'b1, 2'b01, 32'h12, 32'hABCD_1234, 32'h0, 1'b0, lat, bz);
      total++; if (lat != 3) begin bad++; $display("FAIL half_store_lat got=%0d expected=3", lat); end
      send(0, 1'b0, 2'b00, 32'h10, 32'h0, 32'h1234AAEF, 1'b0, lat, bz);
      send(0, 1'b0, 2'b01, 32'h12, 32'h0, 32'h0000_1234, 1'b0, lat, bz);
      total++; if (lat != 2) begin bad++; $display("FAIL half_load_lat got=%0d expected=2", lat); end
   endtask

   task automatic test_errors();
      int lat; logic bz;
      send(0, 1'b0, 2'b01, 32'h11, 32'h0, 32'h0, 1'b1, lat, bz);
      total++; if (lat != 1) begin bad++; $display("FAIL err_half_lat got=%0d expected=1", lat); end
      send(0, 1'b0, 2'b11, 32'h10, 32'h0, 32'h0, 1'b1, lat, bz);
      total++; if (lat != 1) begin bad++; $display("FAIL err_size_lat got=%0d expected=1", lat); end
      send(0, 1'b1, 2'b00, 32'h400, 32'h1111_2222, 32'h0, 1'b1, lat, bz);
      total++; if (lat != 1) begin bad++; $display("FAIL err_range_lat got=%0d expected=1", lat); end
      send(0, 1'b0, 2'b00, 32'h10, 32'h0, 32'h1234AAEF, 1'b0, lat, bz);
      total++; if (lat != 2) begin bad++; $display("FAIL err_after_lat got=%0d expected=2", lat); end
   endtask

   task automatic test_reset_mid();
      int lat; logic bz;
      @(negedge clk);
      wr = 1'b1; size = 2'b10; addr = 32'h10; wdata = 32'h55; req0 = 1'b1;
      @(posedge clk);          // accept: ACCESS next
      #1 req0 = 1'b0;
      @(posedge clk);          // now in MERGE
      #1;
      total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL mid_busy_before got=%b expected=1", busy0); end
      reset = 1'b0;
      #1;
      total++; if (busy0 !== 1'b0)   begin bad++; $display("FAIL mid_busy got=%b expected=0", busy0); end
      total++; if (ready0 !== 1'b0)  begin bad++; $display("FAIL mid_ready got=%b expected=0", ready0); end
      total++; if (rdata0 !== 32'h0) begin bad++; $display("FAIL mid_rdata got=%h expected=0", rdata0); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      send(0, 1'b0, 2'b00, 32'h10, 32'h0, 32'h1234AAEF, 1'b0, lat, bz);
      total++; if (lat != 2) begin bad++; $display("FAIL mid_after_lat got=%0d expected=2", lat); end
   endtask

   task automatic test_wait3();
      int lat; logic bz;
      send(3, 1'b1, 2'b00, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0, lat, bz);
      total++; if (lat != 5) begin bad++; $display("FAIL w3_store_lat got=%0d expected=5", lat); end
      send(3, 1'b0, 2'b00, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, lat, bz);
      total++; if (lat != 5) begin bad++; $display("FAIL w3_load_lat got=%0d expected=5", lat); end
      total++; if (bz !== 1'b1) begin bad++; $display("FAIL w3_busy got=%b expected=1", bz); end
      send(3, 1'b1, 2'b10, 32'h21, 32'h77, 32'h0, 1'b0, lat, bz);
      total++; if (lat != 6) begin bad++; $display("FAIL w3_byte_lat got=%0d expected=6", lat); end
      send(3, 1'b0, 2'b00, 32'h20, 32'h0, 32'hCAFE770D, 1'b0, lat, bz);
      send(3, 1'b0, 2'b01, 32'h23, 32'h0, 32'h0, 1'b1, lat, bz);
      total++; if (lat != 1) begin bad++; $display("FAIL w3_err_lat got=%0d expected=1", lat); end
   endtask

   // req held high: second acceptance happens on the first DONE exit edge
   // (T+5); req is dropped right after it, so exactly two pulses follow.
   task automatic test_back_to_back();
      exp_t e;
      logic exp_rdy;
      @(negedge clk);
      wr = 1'b0; size = 2'b01; addr = 32'h22; wdata = 32'h0;
      e.rdata = 32'h0000_CAFE; e.err = 1'b0;
      q3.push_back(e);
      q3.push_back(e);
      req3 = 1'b1;
      @(posedge clk);          // T
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk);
         #1;
         if (k == 5) req3 = 1'b0;
         exp_rdy = (k == 5) || (k == 10);
         total++;
         if (ready3 !== exp_rdy) begin
            bad++; $display("FAIL b2b_ready_k%0d got=%b expected=%b", k, ready3, exp_rdy);
         end
         total++;
         if (busy3 !== (k <= 9)) begin
            bad++; $display("FAIL b2b_busy_k%0d got=%b expected=%b", k, busy3, (k <= 9));
         end
      end
   endtask

   initial begin
      test_reset();
      test_word();
      test_byte();
      test_half();
      test_errors();
      test_reset_mid();
      test_wait3();
      test_back_to_back();
      repeat (3) @(posedge clk);
      total++; if (q0.size() != 0) begin bad++; $display("FAIL sb0_pending got=%0d expected=0", q0.size()); end
      total++; if (q3.size() != 0) begin bad++; $display("FAIL sb3_pending got=%0d expected=0", q3.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
